// File: rtl/adc4_discr.sv
// Four-channel pedestal tracker and threshold discriminator for a 12-bit ADC.
// Two pipeline stages: sample capture, then pedestal subtraction with trigger/holdoff.
module adc4_discr #(
    parameter int PED_SHIFT = 4,
    parameter int HOLDOFF_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [47:0]          DIN,
    input  logic [3:0]           CHMASK,
    input  logic [11:0]          THR,
    input  logic [HOLDOFF_W-1:0] HOLDOFF,
    output logic [51:0]          DOUT,
    output logic [3:0]           TRIG,
    output logic [47:0]          PED
);

    localparam int NCH    = 4;
    localparam int DATA_W = 12;
    localparam int DIFF_W = DATA_W + 1;
    localparam int ACC_W  = DATA_W + PED_SHIFT;

    function automatic logic [DATA_W-1:0] f_ped(input logic [ACC_W-1:0] acc);
        return acc[ACC_W-1:PED_SHIFT];
    endfunction

    function automatic logic signed [DIFF_W-1:0] f_diff(input logic [DATA_W-1:0] s,
                                                        input logic [DATA_W-1:0] p);
        return $signed({1'b0, s}) - $signed({1'b0, p});
    endfunction

    logic        [DATA_W-1:0]    w_samp_p0 [NCH];
    logic        [DATA_W-1:0]    r_samp_p1 [NCH];
    logic        [ACC_W-1:0]     r_acc     [NCH];
    logic        [ACC_W-1:0]     w_acc_nxt [NCH];
    logic        [DATA_W-1:0]    w_ped     [NCH];
    logic signed [DIFF_W-1:0]    w_diff_p1 [NCH];
    logic signed [DIFF_W-1:0]    r_dout_p2 [NCH];
    logic        [HOLDOFF_W-1:0] r_hold    [NCH];
    logic        [NCH-1:0]       r_armed;
    logic        [NCH-1:0]       r_trig_p2;
    logic                        r_preload;
    logic signed [DIFF_W-1:0]    w_thr;
    logic        [NCH-1:0]       w_over;
    logic        [NCH-1:0]       w_hold_z;
    logic        [NCH-1:0]       w_fire;
    logic        [NCH-1:0]       w_upd;

    // The preload cycle reports zero amplitude so the fresh pedestal never looks like a pulse.
    always_comb begin
        w_thr = $signed({1'b0, THR});
        for (int k = 0; k < NCH; k++) begin
            w_samp_p0[k] = {DIN[12*k+6 +: 6], DIN[12*k +: 6]};
            w_ped[k]     = f_ped(r_acc[k]);
            w_diff_p1[k] = r_preload ? '0 : f_diff(r_samp_p1[k], w_ped[k]);
            w_over[k]    = w_diff_p1[k] > w_thr;
            w_hold_z[k]  = (r_hold[k] == '0);
            w_fire[k]    = CHMASK[k] && r_armed[k] && w_hold_z[k] && w_over[k];
            w_upd[k]     = CHMASK[k] && w_hold_z[k] && !w_over[k];
            if (r_preload) begin
                w_acc_nxt[k] = {r_samp_p1[k], {PED_SHIFT{1'b0}}};
            end else if (w_upd[k]) begin
                w_acc_nxt[k] = r_acc[k] + ACC_W'(r_samp_p1[k]) - ACC_W'(w_ped[k]);
            end else begin
                w_acc_nxt[k] = r_acc[k];
            end
        end
    end

    // Stage 1: sample capture
    always_ff @(posedge CLK) begin
        for (int k = 0; k < NCH; k++) begin
            r_samp_p1[k] <= w_samp_p0[k];
        end
    end

    // Stage 2: amplitude, trigger, pedestal and holdoff state
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_preload <= 1'b1;
            r_armed   <= '0;
            r_trig_p2 <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_acc[k]     <= '0;
                r_hold[k]    <= '0;
                r_dout_p2[k] <= '0;
            end
        end else begin
            r_preload <= 1'b0;
            r_trig_p2 <= w_fire;
            for (int k = 0; k < NCH; k++) begin
                r_acc[k]     <= w_acc_nxt[k];
                r_dout_p2[k] <= CHMASK[k] ? w_diff_p1[k] : '0;
                if (!CHMASK[k] || w_fire[k]) begin
                    r_armed[k] <= 1'b0;
                end else if (!w_over[k] && w_hold_z[k]) begin
                    r_armed[k] <= 1'b1;
                end
                if (!CHMASK[k]) begin
                    r_hold[k] <= '0;
                end else if (w_fire[k]) begin
                    r_hold[k] <= HOLDOFF;
                end else if (!w_hold_z[k]) begin
                    r_hold[k] <= r_hold[k] - HOLDOFF_W'(1);
                end
            end
        end
    end

    always_comb begin
        DOUT = '0;
        PED  = '0;
        TRIG = r_trig_p2;
        for (int k = 0; k < NCH; k++) begin
            DOUT[13*k +: 13] = r_dout_p2[k];
            PED[12*k +: 12]  = w_ped[k];
        end
    end

endmodule
